serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 138 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller around one Full_adder (optional overflow output: SERIAL_ADD_OVF_EN)

// Single-bit full adder; the only arithmetic element in the serial datapath.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADD_OVF_EN
  output logic             V,
`endif
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  Full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Sum bits enter at the MSB so the LSB-first stream lands in natural order.
  generate
    if (WIDTH == 1) begin : g_s1
      assign s_next = fa_sum;
    end else begin : g_sn
      assign s_next = {fa_sum, s_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, one bit per RUN cycle, and result capture on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      V     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
            s_sh  <= '0;
          end
        end
        RUN: begin
          s_sh  <= s_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            S    <= s_next;
            Cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // carry here is the carry into the MSB position.
            V    <= carry ^ fa_cout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=3 and WIDTH=1)
module tb_serial_add_ctrl;
  localparam int W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] s;
  logic         start1, a1, b1, c1;
  logic         busy1, done1, s1, cout1;
`ifdef SERIAL_ADD_OVF_EN
  logic         v, v1;
`endif

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin),
    .busy(busy), .done(done), .S(s),
`ifdef SERIAL_ADD_OVF_EN
    .V(v),
`endif
    .Cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(c1),
    .busy(busy1), .done(done1), .S(s1),
`ifdef SERIAL_ADD_OVF_EN
    .V(v1),
`endif
    .Cout(cout1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Signed overflow of A+B+Cin as two's-complement W-bit values.
  function automatic bit ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int sx, sy, t;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    t  = sx + sy + int'(c);
    return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
  endfunction

  // Transaction-level model: one op in flight, result after W cycles, idle W+2 after accept.
  int  en = 0;
  int  acc_k = -100;
  bit  inflight = 0;
  bit  mvalid = 0;
  int  pend = 0, res = 0;
  bit  pend_v = 0, res_v = 0;

  always @(posedge clk) begin
    en++;
    mvalid = 1;
    if (rst) begin
      inflight = 0;
      res = 0;
      res_v = 0;
    end else if (!inflight) begin
      if (start) begin
        inflight = 1;
        acc_k = en;
        pend = int'(a) + int'(b) + int'(cin);
        pend_v = ovf(a, b, cin);
      end
    end else begin
      if (en == acc_k + W) begin
        res = pend;
        res_v = pend_v;
      end
      if (en == acc_k + W + 1) inflight = 0;
    end
  end

  // Compare the W=3 instance against the model every cycle.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy", busy, inflight);
      chk("done", done, inflight && (en == acc_k + W));
      chk("result", {cout, s}, res);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", v, res_v);
`endif
    end
  end

  task automatic op(input int x, input int y, input int c, input bit scramble, output int lat);
    bit got;
    @(negedge clk);
    start = 1; a = x[W-1:0]; b = y[W-1:0]; cin = c[0];
    @(negedge clk);
    start = 0;
    if (scramble) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
    end
    lat = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, dones, seen;
    rst = 1; start = 0; a = 0; b = 0; cin = 0;
    start1 = 0; a1 = 0; b1 = 0; c1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", {cout, s}, 0);
    rst = 0;

    op(3, 2, 0, 0, lat);
    chk("t1_latency", lat, 3);
    chk("t1_s", s, 5);
    chk("t1_cout", cout, 0);

    op(7, 1, 0, 1, lat);
    chk("t2_s", s, 0);
    chk("t2_cout", cout, 1);
    op(7, 7, 1, 1, lat);
    chk("t3_s", s, 7);
    chk("t3_cout", cout, 1);
    repeat (10) @(negedge clk);
    chk("hold_s", s, 7);
    chk("hold_cout", cout, 1);

    @(negedge clk);
    start = 1; a = 1; b = 1; cin = 0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 0;
    chk("stream_dones", dones, 3);
    chk("stream_s", s, 2);

    @(negedge clk);
    start = 1; a = 5; b = 6; cin = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", {cout, s}, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    op(1, 2, 0, 0, lat);
    chk("after_abort_s", s, 3);

`ifdef SERIAL_ADD_OVF_EN
    op(3, 1, 0, 0, lat);
    chk("ovf1_s", s, 4);
    chk("ovf1_v", v, 1);
    op(7, 1, 0, 0, lat);
    chk("ovf2_s", s, 0);
    chk("ovf2_cout", cout, 1);
    chk("ovf2_v", v, 0);
`endif

    for (int x = 0; x < (1 << W); x++)
      for (int y = 0; y < (1 << W); y++)
        for (int c = 0; c < 2; c++) begin
          op(x, y, c, 1, lat);
          chk("sweep3", {cout, s}, x + y + c);
        end

    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++) begin
          bit got;
          @(negedge clk);
          start1 = 1; a1 = x[0]; b1 = y[0]; c1 = c[0];
          @(negedge clk);
          start1 = 0;
          lat = 0;
          got = 0;
          for (int i = 0; i < 5; i++) begin
            if (done1) begin
              got = 1;
              break;
            end
            @(negedge clk);
            lat++;
          end
          if (!got) chk("w1_timeout", 0, 1);
          chk("w1_latency", lat, 1);
          chk("sweep1", {cout1, s1}, x + y + c);
        end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
